cu_fsm_mc: RTL and testbench

- Multi-cycle control unit for the OTTER RV32I core, replacing the fixed-latency fetch/decode/writeback FSM.
- Adds ready/valid handshakes to instruction and data memory, with a bounded wait timeout.
- Adds a parametrised vectored interrupt controller with per-line enables and lowest-index priority.
- Adds precise exceptions (illegal instruction, bus timeout) and an explicit MRET strobe.
- Sits between the IR/decoder fields and the PC, register file, memory and CSR write enables.

---
 rtl/cu_mc_pkg.sv | 44 ++++
 rtl/cu_irq_prio.sv | 23 ++
 rtl/cu_fsm_mc.sv | 241 ++++++++++++++++++++++++
 tb/tb_cu_fsm_mc.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/cu_mc_pkg.sv
// Shared types and constants for the OTTER multi-cycle control unit.
// Opcode/func3 encodings follow the RV32I base ISA.
package cu_mc_pkg;

  typedef enum logic [6:0] {
    LUI    = 7'b0110111,
    AUIPC  = 7'b0010111,
    JAL    = 7'b1101111,
    JALR   = 7'b1100111,
    BRANCH = 7'b1100011,
    LOAD   = 7'b0000011,
    STORE  = 7'b0100011,
    OP_IMM = 7'b0010011,
    OP_RG3 = 7'b0110011,
    CSR    = 7'b1110011
  } opcode_t;

  typedef enum logic [2:0] {
    MRET  = 3'b000,
    CSRRW = 3'b001
  } csr_func3_t;

  typedef enum logic [2:0] {
    FETCH,
    DECODE,
    MEM_WAIT,
    WRITEBACK,
    TRAP
  } state_t;

  localparam logic [1:0] EXC_NONE    = 2'b00;
  localparam logic [1:0] EXC_ILLEGAL = 2'b01;
  localparam logic [1:0] EXC_BUS     = 2'b10;

  function automatic int id_width(input int num_irq);
    return (num_irq > 1) ? $clog2(num_irq) : 1;
  endfunction

  // A zero timeout still needs a one-bit counter to keep the declarations legal.
  function automatic int cnt_width(input int timeout);
    return (timeout < 1) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/cu_irq_prio.sv
// Combinational priority encoder: reports whether any line is pending and
// the lowest pending index.
module cu_irq_prio
  import cu_mc_pkg::*;
#(
  parameter  int NUM_IRQ = 4,
  localparam int IDW     = id_width(NUM_IRQ)
) (
  input  logic [NUM_IRQ-1:0] pend,
  output logic               any,
  output logic [IDW-1:0]     id
);

  // Scanning from the top down lets the lowest set index win by overwriting.
  always_comb begin
    any = |pend;
    id  = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (pend[i]) id = IDW'(i);
    end
  end

endmodule

// File: rtl/cu_fsm_mc.sv
// Multi-cycle OTTER control unit with ready/valid memory waits, bounded
// timeouts, precise exceptions and a vectored interrupt entry.
module cu_fsm_mc
  import cu_mc_pkg::*;
#(
  parameter  int NUM_IRQ     = 4,
  parameter  int MEM_TIMEOUT = 15,
  localparam int IDW         = id_width(NUM_IRQ)
) (
  input  logic               clk,
  input  logic               RST,
  input  logic [6:0]         opcode,
  input  logic [2:0]         func3,
  input  logic               imem_ready,
  input  logic               dmem_ready,
  input  logic               mie,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic [NUM_IRQ-1:0] irq_en,
  output logic               pcWrite,
  output logic               regWrite,
  output logic               memWE2,
  output logic               memRDEN1,
  output logic               memRDEN2,
  output logic               csr_WE,
  output logic               mret_exec,
  output logic               int_taken,
  output logic               exc_taken,
  output logic [1:0]         exc_code,
  output logic [IDW-1:0]     int_id
);

  localparam int               CNT_W      = cnt_width(MEM_TIMEOUT);
  localparam bit               TIMEOUT_ON = (MEM_TIMEOUT > 0);
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  state_t           r_state;
  logic [CNT_W-1:0] r_wait_cnt;
  logic [1:0]       r_exc_code;
  logic [IDW-1:0]   r_int_id;
  logic             r_is_store;

  state_t           w_next;
  opcode_t          w_op;
  csr_func3_t       w_f3;
  logic [NUM_IRQ-1:0] w_pend;
  logic             w_irq_any;
  logic [IDW-1:0]   w_irq_id;
  logic             w_expired;
  logic             w_complete;
  logic             w_illegal;
  logic             w_exc_set;
  logic [1:0]       w_exc_new;
  logic             w_int_set;

  logic             w_pc_write, w_reg_write, w_mem_we2, w_mem_rden1, w_mem_rden2;
  logic             w_csr_we, w_mret, w_int_taken, w_exc_taken;
  logic [1:0]       w_exc_code;
  logic [IDW-1:0]   w_int_id;

  assign w_op      = opcode_t'(opcode);
  assign w_f3      = csr_func3_t'(func3);
  assign w_pend    = irq & irq_en & {NUM_IRQ{mie}};
  // The counter reads N-1 on the N-th waiting cycle, so the last allowed cycle is CNT_LAST.
  assign w_expired = TIMEOUT_ON && (r_wait_cnt == CNT_LAST);

  cu_irq_prio #(.NUM_IRQ(NUM_IRQ)) u_irq_prio (
    .pend (w_pend),
    .any  (w_irq_any),
    .id   (w_irq_id)
  );

  // NOTE: every signal written here gets a default first, so no path leaves one unassigned (no latches).
  always_comb begin
    w_next      = r_state;
    w_complete  = 1'b0;
    w_illegal   = 1'b0;
    w_exc_set   = 1'b0;
    w_exc_new   = EXC_NONE;
    w_int_set   = 1'b0;
    w_pc_write  = 1'b0;
    w_reg_write = 1'b0;
    w_mem_we2   = 1'b0;
    w_mem_rden1 = 1'b0;
    w_mem_rden2 = 1'b0;
    w_csr_we    = 1'b0;
    w_mret      = 1'b0;
    w_int_taken = 1'b0;
    w_exc_taken = 1'b0;
    w_exc_code  = EXC_NONE;
    w_int_id    = '0;

    case (r_state)
      FETCH: begin
        w_mem_rden1 = 1'b1;
        if (imem_ready) begin
          w_next = DECODE;
        end else if (w_expired) begin
          w_next    = TRAP;
          w_exc_set = 1'b1;
          w_exc_new = EXC_BUS;
        end
      end

      DECODE: begin
        case (w_op)
          LUI, AUIPC, JAL, JALR, OP_IMM, OP_RG3: begin
            w_reg_write = 1'b1;
            w_pc_write  = 1'b1;
            w_complete  = 1'b1;
          end
          BRANCH: begin
            w_pc_write = 1'b1;
            w_complete = 1'b1;
          end
          LOAD: begin
            w_mem_rden2 = 1'b1;
            w_next      = MEM_WAIT;
          end
          STORE: begin
            w_mem_we2 = 1'b1;
            w_next    = MEM_WAIT;
          end
          CSR: begin
            case (w_f3)
              CSRRW: begin
                w_csr_we    = 1'b1;
                w_reg_write = 1'b1;
                w_pc_write  = 1'b1;
                w_complete  = 1'b1;
              end
              MRET: begin
                w_mret     = 1'b1;
                w_pc_write = 1'b1;
                w_complete = 1'b1;
              end
              default: w_illegal = 1'b1;
            endcase
          end
          default: w_illegal = 1'b1;
        endcase
      end

      MEM_WAIT: begin
        w_mem_we2   = r_is_store;
        w_mem_rden2 = !r_is_store;
        if (dmem_ready) begin
          if (r_is_store) begin
            w_pc_write = 1'b1;
            w_complete = 1'b1;
          end else begin
            w_next = WRITEBACK;
          end
        end else if (w_expired) begin
          w_next    = TRAP;
          w_exc_set = 1'b1;
          w_exc_new = EXC_BUS;
        end
      end

      WRITEBACK: begin
        w_reg_write = 1'b1;
        w_mem_rden2 = 1'b1;
        w_pc_write  = 1'b1;
        w_complete  = 1'b1;
      end

      TRAP: begin
        w_pc_write = 1'b1;
        w_next     = FETCH;
        if (r_exc_code != EXC_NONE) begin
          w_exc_taken = 1'b1;
          w_exc_code  = r_exc_code;
        end else begin
          w_int_taken = 1'b1;
          w_int_id    = r_int_id;
        end
      end

      default: w_next = FETCH;
    endcase

    if (w_illegal) begin
      w_next    = TRAP;
      w_exc_set = 1'b1;
      w_exc_new = EXC_ILLEGAL;
    end

    // Interrupts are only considered on the cycle that retires an instruction.
    if (w_complete) begin
      if (w_irq_any) begin
        w_next    = TRAP;
        w_int_set = 1'b1;
      end else begin
        w_next = FETCH;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      r_state    <= FETCH;
      r_wait_cnt <= '0;
      r_exc_code <= EXC_NONE;
      r_int_id   <= '0;
      r_is_store <= 1'b0;
    end else begin
      r_state <= w_next;

      if (w_next != r_state) begin
        r_wait_cnt <= '0;
      end else if ((r_state == FETCH || r_state == MEM_WAIT) && (r_wait_cnt != '1)) begin
        r_wait_cnt <= r_wait_cnt + CNT_W'(1);
      end

      if (w_next == FETCH) begin
        r_exc_code <= EXC_NONE;
        r_int_id   <= '0;
      end else begin
        if (w_exc_set) r_exc_code <= w_exc_new;
        if (w_int_set) r_int_id   <= w_irq_id;
      end

      if (r_state == DECODE) r_is_store <= (w_op == STORE);
    end
  end

  // Reset also masks the outputs so FETCH's memRDEN1 cannot leak while RST is held.
  assign pcWrite   = !RST && w_pc_write;
  assign regWrite  = !RST && w_reg_write;
  assign memWE2    = !RST && w_mem_we2;
  assign memRDEN1  = !RST && w_mem_rden1;
  assign memRDEN2  = !RST && w_mem_rden2;
  assign csr_WE    = !RST && w_csr_we;
  assign mret_exec = !RST && w_mret;
  assign int_taken = !RST && w_int_taken;
  assign exc_taken = !RST && w_exc_taken;
  assign exc_code  = RST ? EXC_NONE : w_exc_code;
  assign int_id    = RST ? '0 : w_int_id;

endmodule

// File: tb/tb_cu_fsm_mc.sv
// Directed cycle-by-cycle bench for cu_fsm_mc (NUM_IRQ=4, MEM_TIMEOUT=15).
// Each cycle's full output vector is compared against a hand-written value.
module tb_cu_fsm_mc;

  localparam logic [8:0] B_PC   = 9'h100;
  localparam logic [8:0] B_RW   = 9'h080;
  localparam logic [8:0] B_WE2  = 9'h040;
  localparam logic [8:0] B_RD1  = 9'h020;
  localparam logic [8:0] B_RD2  = 9'h010;
  localparam logic [8:0] B_CSR  = 9'h008;
  localparam logic [8:0] B_MRET = 9'h004;
  localparam logic [8:0] B_INT  = 9'h002;
  localparam logic [8:0] B_EXC  = 9'h001;

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_CSR    = 7'b1110011;
  localparam logic [6:0] OPC_BAD    = 7'b1111111;

  logic       clk = 1'b0;
  logic       RST;
  logic [6:0] opcode;
  logic [2:0] func3;
  logic       imem_ready, dmem_ready, mie;
  logic [3:0] irq, irq_en;
  logic       pcWrite, regWrite, memWE2, memRDEN1, memRDEN2;
  logic       csr_WE, mret_exec, int_taken, exc_taken;
  logic [1:0] exc_code;
  logic [1:0] int_id;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cu_fsm_mc #(.NUM_IRQ(4), .MEM_TIMEOUT(15)) dut (
    .clk        (clk),
    .RST        (RST),
    .opcode     (opcode),
    .func3      (func3),
    .imem_ready (imem_ready),
    .dmem_ready (dmem_ready),
    .mie        (mie),
    .irq        (irq),
    .irq_en     (irq_en),
    .pcWrite    (pcWrite),
    .regWrite   (regWrite),
    .memWE2     (memWE2),
    .memRDEN1   (memRDEN1),
    .memRDEN2   (memRDEN2),
    .csr_WE     (csr_WE),
    .mret_exec  (mret_exec),
    .int_taken  (int_taken),
    .exc_taken  (exc_taken),
    .exc_code   (exc_code),
    .int_id     (int_id)
  );

  task automatic check(input string tag, input logic [12:0] act, input logic [12:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got ctl=%b code=%b id=%b, expected ctl=%b code=%b id=%b",
               tag, act[12:4], act[3:2], act[1:0], exp[12:4], exp[3:2], exp[1:0]);
    end
  endtask

  // Let combinational outputs settle, then compare the whole output vector.
  task automatic chk(input string tag, input logic [8:0] ctl, input logic [1:0] code, input logic [1:0] id);
    #1;
    check(tag, {pcWrite, regWrite, memWE2, memRDEN1, memRDEN2, csr_WE, mret_exec,
                int_taken, exc_taken, exc_code, int_id}, {ctl, code, id});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One-cycle fetch: present the instruction with imem_ready, then step into DECODE.
  task automatic fetch_one(input string tag, input logic [6:0] opc, input logic [2:0] f3);
    opcode     = opc;
    func3      = f3;
    imem_ready = 1'b1;
    chk(tag, B_RD1, 2'b00, 2'b00);
    tick();
    imem_ready = 1'b0;
  endtask

  initial begin
    RST = 1'b1; opcode = '0; func3 = '0; imem_ready = 1'b0; dmem_ready = 1'b0;
    mie = 1'b0; irq = '0; irq_en = '0;

    chk("reset_held", 9'h000, 2'b00, 2'b00);
    repeat (2) @(posedge clk);
    @(negedge clk);
    RST = 1'b0;
    chk("reset_release_fetch", B_RD1, 2'b00, 2'b00);

    // OP_IMM with imem_ready on the second FETCH cycle.
    opcode = OPC_OP_IMM;
    tick();
    imem_ready = 1'b1;
    chk("opimm_fetch2", B_RD1, 2'b00, 2'b00);
    tick();
    imem_ready = 1'b0;
    chk("opimm_decode", B_PC | B_RW, 2'b00, 2'b00);
    tick();

    // LOAD with dmem_ready on the fourth MEM_WAIT cycle.
    fetch_one("load_fetch", OPC_LOAD, 3'b010);
    chk("load_decode", B_RD2, 2'b00, 2'b00);
    for (int i = 0; i < 4; i++) begin
      tick();
      dmem_ready = (i == 3);
      chk($sformatf("load_wait%0d", i), B_RD2, 2'b00, 2'b00);
    end
    tick();
    dmem_ready = 1'b0;
    chk("load_writeback", B_PC | B_RW | B_RD2, 2'b00, 2'b00);
    tick();

    // STORE that never gets dmem_ready: 15 wait cycles then bus-timeout trap.
    fetch_one("store_fetch", OPC_STORE, 3'b010);
    chk("store_decode", B_WE2, 2'b00, 2'b00);
    for (int i = 0; i < 15; i++) begin
      tick();
      chk($sformatf("store_wait%0d", i), B_WE2, 2'b00, 2'b00);
    end
    tick();
    chk("store_timeout_trap", B_PC | B_EXC, 2'b10, 2'b00);
    tick();
    chk("store_trap_exit", B_RD1, 2'b00, 2'b00);

    // JAL with irq=1100, all enabled: lowest pending index is 2.
    mie = 1'b1; irq = 4'b1100; irq_en = 4'b1111;
    fetch_one("jal_fetch", OPC_JAL, 3'b000);
    chk("jal_decode", B_PC | B_RW, 2'b00, 2'b00);
    tick();
    chk("jal_irq_trap_id2", B_PC | B_INT, 2'b00, 2'b10);
    tick();
    chk("jal_irq_exit", B_RD1, 2'b00, 2'b00);

    // Line 2 masked off: only line 3 remains.
    irq_en = 4'b1011;
    fetch_one("jal2_fetch", OPC_JAL, 3'b000);
    chk("jal2_decode", B_PC | B_RW, 2'b00, 2'b00);
    tick();
    chk("jal2_irq_trap_id3", B_PC | B_INT, 2'b00, 2'b11);
    tick();

    // Global enable off: no trap after completion.
    mie = 1'b0;
    fetch_one("jal3_fetch", OPC_JAL, 3'b000);
    chk("jal3_decode", B_PC | B_RW, 2'b00, 2'b00);
    tick();
    chk("jal3_no_trap", B_RD1, 2'b00, 2'b00);

    // Illegal CSR func3 with an interrupt pending: exception wins.
    mie = 1'b1; irq_en = 4'b1111;
    fetch_one("illcsr_fetch", OPC_CSR, 3'b010);
    chk("illcsr_decode", 9'h000, 2'b00, 2'b00);
    tick();
    chk("illcsr_trap", B_PC | B_EXC, 2'b01, 2'b00);
    tick();
    mie = 1'b0; irq = '0;

    // Unknown opcode.
    fetch_one("badop_fetch", OPC_BAD, 3'b000);
    chk("badop_decode", 9'h000, 2'b00, 2'b00);
    tick();
    chk("badop_trap", B_PC | B_EXC, 2'b01, 2'b00);
    tick();

    // MRET, CSRRW and BRANCH decode.
    fetch_one("mret_fetch", OPC_CSR, 3'b000);
    chk("mret_decode", B_PC | B_MRET, 2'b00, 2'b00);
    tick();
    fetch_one("csrrw_fetch", OPC_CSR, 3'b001);
    chk("csrrw_decode", B_PC | B_RW | B_CSR, 2'b00, 2'b00);
    tick();
    fetch_one("branch_fetch", OPC_BRANCH, 3'b000);
    chk("branch_decode", B_PC, 2'b00, 2'b00);
    tick();

    // Instruction fetch timeout.
    for (int i = 0; i < 15; i++) begin
      chk($sformatf("ifetch_wait%0d", i), B_RD1, 2'b00, 2'b00);
      tick();
    end
    chk("ifetch_timeout_trap", B_PC | B_EXC, 2'b10, 2'b00);
    tick();

    // Asynchronous reset in the middle of a MEM_WAIT cycle.
    fetch_one("rst_load_fetch", OPC_LOAD, 3'b010);
    chk("rst_load_decode", B_RD2, 2'b00, 2'b00);
    tick();
    chk("rst_load_wait", B_RD2, 2'b00, 2'b00);
    #1 RST = 1'b1;
    chk("rst_async_outputs", 9'h000, 2'b00, 2'b00);
    @(negedge clk);
    RST = 1'b0;
    chk("rst_mid_release", B_RD1, 2'b00, 2'b00);
    tick();
    chk("rst_fetch_next", B_RD1, 2'b00, 2'b00);
    fetch_one("rst_opimm_fetch", OPC_OP_IMM, 3'b000);
    chk("rst_opimm_decode", B_PC | B_RW, 2'b00, 2'b00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
